// File: rtl/pc_sequencer.sv
// Program-counter sequencer: selects jump/return/increment each cycle and runs the
// interrupt entry sequence (drain, push return address as two halfwords, vector).
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0020,
  parameter logic [31:0] INT_VEC      = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        int_req,
  input  logic        jmp_req,
  input  logic [31:0] jmp_dst,
  input  logic        ret_req,
  input  logic [31:0] ret_pc,
  input  logic [31:0] pc_cur,
  output logic        pc_load,
  output logic [31:0] pc_load_val,
  output logic        pc_hold,
  output logic        flush,
  output logic        push_en,
  output logic [15:0] push_data,
  output logic        int_ack,
  output logic        busy
);

  typedef enum logic [2:0] {
    StRun,
    StDrain,
    StPushHi,
    StPushLo,
    StVector
  } state_e;

  state_e      state_q;
  logic        int_pending_q;
  logic [3:0]  cnt_q;
  logic [31:0] saved_pc_q;
  logic        start_entry;
  logic [31:0] entry_pc;

  assign start_entry = (state_q == StRun) && !stall && int_pending_q;

  // A redirect in the entry cycle is not taken; it becomes the return address instead.
  assign entry_pc = jmp_req ? jmp_dst : (ret_req ? ret_pc : pc_cur);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StRun;
      int_pending_q <= 1'b0;
      cnt_q         <= 4'd0;
      saved_pc_q    <= 32'h0;
    end else begin
      if (int_req) begin
        int_pending_q <= 1'b1;
      end else if (state_q == StVector) begin
        int_pending_q <= 1'b0;
      end

      case (state_q)
        StRun: begin
          if (start_entry) begin
            state_q    <= StDrain;
            cnt_q      <= 4'(FLUSH_CYCLES - 1);
            saved_pc_q <= entry_pc;
          end
        end
        StDrain: begin
          if (cnt_q == 4'd0) begin
            state_q <= StPushHi;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StPushHi: state_q <= StPushLo;
        StPushLo: state_q <= StVector;
        StVector: state_q <= StRun;
        default:  state_q <= StRun;
      endcase
    end
  end

  always_comb begin
    pc_load     = 1'b0;
    pc_load_val = 32'h0;
    pc_hold     = 1'b0;
    flush       = 1'b0;
    push_en     = 1'b0;
    push_data   = 16'h0000;
    int_ack     = 1'b0;
    busy        = (state_q != StRun);

    case (state_q)
      StRun: begin
        if (stall) begin
          pc_hold = 1'b1;
        end else if (int_pending_q) begin
          pc_hold = 1'b1;
          flush   = 1'b1;
        end else if (jmp_req) begin
          pc_load     = 1'b1;
          pc_load_val = jmp_dst;
          flush       = 1'b1;
        end else if (ret_req) begin
          pc_load     = 1'b1;
          pc_load_val = ret_pc;
          flush       = 1'b1;
        end
      end
      StDrain: begin
        pc_hold = 1'b1;
        flush   = 1'b1;
      end
      StPushHi: begin
        pc_hold   = 1'b1;
        push_en   = 1'b1;
        push_data = saved_pc_q[31:16];
      end
      StPushLo: begin
        pc_hold   = 1'b1;
        push_en   = 1'b1;
        push_data = saved_pc_q[15:0];
      end
      StVector: begin
        pc_load     = 1'b1;
        pc_load_val = INT_VEC;
        flush       = 1'b1;
        int_ack     = 1'b1;
      end
      default: ;
    endcase

    // Reset overrides whatever state the sequencer is in.
    if (reset) begin
      pc_load     = 1'b1;
      pc_load_val = RESET_PC;
      pc_hold     = 1'b0;
      flush       = 1'b1;
      push_en     = 1'b0;
      push_data   = 16'h0000;
      int_ack     = 1'b0;
      busy        = 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fixed per-cycle vectors with hand-computed outputs,
// default parameters (RESET_PC=0x20, INT_VEC=0, FLUSH_CYCLES=3).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        int_req;
  logic        jmp_req;
  logic [31:0] jmp_dst;
  logic        ret_req;
  logic [31:0] ret_pc;
  logic [31:0] pc_cur;
  logic        pc_load;
  logic [31:0] pc_load_val;
  logic        pc_hold;
  logic        flush;
  logic        push_en;
  logic [15:0] push_data;
  logic        int_ack;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .int_req    (int_req),
    .jmp_req    (jmp_req),
    .jmp_dst    (jmp_dst),
    .ret_req    (ret_req),
    .ret_pc     (ret_pc),
    .pc_cur     (pc_cur),
    .pc_load    (pc_load),
    .pc_load_val(pc_load_val),
    .pc_hold    (pc_hold),
    .flush      (flush),
    .push_en    (push_en),
    .push_data  (push_data),
    .int_ack    (int_ack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs are already set for this cycle; compare outputs mid-cycle, then advance.
  task automatic cyc(input string tag, input bit ld, input logic [31:0] val, input bit hold,
                     input bit fl, input bit push, input logic [15:0] pd, input bit ack,
                     input bit bsy);
    #1;
    check({tag, ".pc_load"},     32'(pc_load),   32'(ld));
    check({tag, ".pc_load_val"}, pc_load_val,    val);
    check({tag, ".pc_hold"},     32'(pc_hold),   32'(hold));
    check({tag, ".flush"},       32'(flush),     32'(fl));
    check({tag, ".push_en"},     32'(push_en),   32'(push));
    check({tag, ".push_data"},   32'(push_data), 32'(pd));
    check({tag, ".int_ack"},     32'(int_ack),   32'(ack));
    check({tag, ".busy"},        32'(busy),      32'(bsy));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    stall   = 1'b0;
    int_req = 1'b0;
    jmp_req = 1'b0;
    ret_req = 1'b0;
    jmp_dst = 32'h0;
    ret_pc  = 32'h0;
    pc_cur  = 32'h0000_0100;

    // Reset for two cycles, then idle increment
    cyc("rst0", 1, 32'h20, 0, 1, 0, 16'h0, 0, 0);
    cyc("rst1", 1, 32'h20, 0, 1, 0, 16'h0, 0, 0);
    reset = 1'b0;
    cyc("idle", 0, 32'h0, 0, 0, 0, 16'h0, 0, 0);

    // Basic interrupt entry from pc_cur
    pc_cur  = 32'h0001_2345;
    int_req = 1'b1;
    cyc("i36_req", 0, 32'h0, 0, 0, 0, 16'h0, 0, 0);
    int_req = 1'b0;
    cyc("i36_start", 0, 32'h0, 1, 1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("i36_drain", 0, 32'h0, 1, 1, 0, 16'h0, 0, 1);
    cyc("i36_hi", 0, 32'h0, 1, 0, 1, 16'h0001, 0, 1);
    cyc("i36_lo", 0, 32'h0, 1, 0, 1, 16'h2345, 0, 1);
    cyc("i36_vec", 1, 32'h0, 0, 1, 0, 16'h0, 1, 1);
    cyc("i36_after", 0, 32'h0, 0, 0, 0, 16'h0, 0, 0);

    // Jump in the entry cycle becomes the saved PC; later stall/jmp/ret are ignored
    int_req = 1'b1;
    cyc("i37_req", 0, 32'h0, 0, 0, 0, 16'h0, 0, 0);
    int_req = 1'b0;
    jmp_req = 1'b1;
    jmp_dst = 32'h0000_0040;
    cyc("i37_start", 0, 32'h0, 1, 1, 0, 16'h0, 0, 0);
    stall   = 1'b1;
    ret_req = 1'b1;
    jmp_dst = 32'h0000_0999;
    ret_pc  = 32'h0000_0777;
    for (int i = 0; i < 3; i++) cyc("i37_drain", 0, 32'h0, 1, 1, 0, 16'h0, 0, 1);
    cyc("i37_hi", 0, 32'h0, 1, 0, 1, 16'h0000, 0, 1);
    cyc("i37_lo", 0, 32'h0, 1, 0, 1, 16'h0040, 0, 1);
    cyc("i37_vec", 1, 32'h0, 0, 1, 0, 16'h0, 1, 1);
    stall   = 1'b0;
    jmp_req = 1'b0;
    ret_req = 1'b0;
    cyc("i37_after", 0, 32'h0, 0, 0, 0, 16'h0, 0, 0);

    // Stalled jump holds, then loads once stall drops
    jmp_req = 1'b1;
    jmp_dst = 32'h0000_1234;
    stall   = 1'b1;
    cyc("i38_stall0", 0, 32'h0, 1, 0, 0, 16'h0, 0, 0);
    cyc("i38_stall1", 0, 32'h0, 1, 0, 0, 16'h0, 0, 0);
    stall = 1'b0;
    cyc("i38_go", 1, 32'h0000_1234, 0, 1, 0, 16'h0, 0, 0);

    // Jump beats return; return alone
    ret_req = 1'b1;
    jmp_dst = 32'h0000_0010;
    ret_pc  = 32'h0000_0030;
    cyc("i39_both", 1, 32'h0000_0010, 0, 1, 0, 16'h0, 0, 0);
    jmp_req = 1'b0;
    cyc("i39_ret", 1, 32'h0000_0030, 0, 1, 0, 16'h0, 0, 0);
    ret_req = 1'b0;

    // int_req held through entry: re-entry only after a RUN cycle
    pc_cur  = 32'hABCD_0004;
    int_req = 1'b1;
    cyc("i29_req", 0, 32'h0, 0, 0, 0, 16'h0, 0, 0);
    cyc("i29_start", 0, 32'h0, 1, 1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("i29_drain", 0, 32'h0, 1, 1, 0, 16'h0, 0, 1);
    cyc("i29_hi", 0, 32'h0, 1, 0, 1, 16'hABCD, 0, 1);
    cyc("i29_lo", 0, 32'h0, 1, 0, 1, 16'h0004, 0, 1);
    cyc("i29_vec", 1, 32'h0, 0, 1, 0, 16'h0, 1, 1);
    cyc("i29_run", 0, 32'h0, 1, 1, 0, 16'h0, 0, 0);
    int_req = 1'b0;
    for (int i = 0; i < 3; i++) cyc("i40_drain", 0, 32'h0, 1, 1, 0, 16'h0, 0, 1);

    // Reset in PUSH_HI aborts the sequence
    reset = 1'b1;
    cyc("i40_rst", 1, 32'h20, 0, 1, 0, 16'h0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) cyc("i40_idle", 0, 32'h0, 0, 0, 0, 16'h0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
